imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: receives a program over an 8N1 serial line into a 256x8
// instruction memory and holds the CPU in reset until the program is complete.
// The first byte of a load is the program length (0 means 256); the bytes that
// follow fill memory from address 0. Instruction reads return 0 outside the
// loaded program and whenever the loader is not in RUN.
module imem_loader #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       Clk_O,
  input  logic       Reset,
  input  logic       Rx,
  input  logic       Reload,
  input  logic [7:0] PC,
  output logic [7:0] Instruction,
  output logic       CPU_Reset,
  output logic       Loading,
  output logic [7:0] Load_Count,
  output logic       Frame_Error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    WAIT_LEN,
    LOAD,
    RUN
  } ld_state_t;

  // Synchronizer and receiver state
  logic             rx_meta;
  logic             rx_sync;
  logic [1:0]       sync_fill;
  logic             rx_armed;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_shift;
  logic             stop_wait;
  logic             byte_valid;
  logic             frame_err;

  // Loader state
  ld_state_t        ld_state;
  logic [8:0]       length;
  logic [8:0]       written;
  logic [7:0]       write_addr;
  logic             mem_we;
  logic [7:0]       mem [0:255];

  // Two-flop synchronizer; sync_fill marks when rx_sync reflects the real line
  // rather than its reset value, so a line held low across reset is not
  // mistaken for a start bit.
  always_ff @(posedge Clk_O) begin
    if (!Reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      sync_fill <= 2'b00;
    end else begin
      rx_meta   <= Rx;
      rx_sync   <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  // Serial receiver: mid-bit sampling, start-bit glitch rejection, and a
  // one-cycle byte_valid / frame_err pulse at the stop-bit sample.
  always_ff @(posedge Clk_O) begin
    if (!Reset) begin
      rx_state   <= RX_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= 3'd0;
      rx_shift   <= 8'h00;
      stop_wait  <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      rx_armed   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (sync_fill[1] && rx_sync) begin
        rx_armed <= 1'b1;
      end
      case (rx_state)
        RX_IDLE: begin
          clk_cnt   <= '0;
          bit_idx   <= 3'd0;
          stop_wait <= 1'b0;
          if (rx_armed && !rx_sync) begin
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt  <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt  <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              rx_state <= RX_STOP;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (stop_wait) begin
            if (rx_sync) begin
              stop_wait <= 1'b0;
              rx_state  <= RX_IDLE;
            end
          end else if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              rx_state   <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              stop_wait <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // A received byte is written only while loading and never in a Reload cycle.
  assign mem_we = Reset && !Reload && (ld_state == LOAD) && byte_valid;

  // Loader FSM with registered status outputs; Reload outranks received bytes.
  always_ff @(posedge Clk_O) begin
    if (!Reset) begin
      ld_state    <= WAIT_LEN;
      length      <= 9'd0;
      written     <= 9'd0;
      write_addr  <= 8'h00;
      Load_Count  <= 8'h00;
      Frame_Error <= 1'b0;
      CPU_Reset   <= 1'b1;
      Loading     <= 1'b1;
    end else if (Reload) begin
      ld_state    <= WAIT_LEN;
      written     <= 9'd0;
      write_addr  <= 8'h00;
      Load_Count  <= 8'h00;
      Frame_Error <= 1'b0;
      CPU_Reset   <= 1'b1;
      Loading     <= 1'b1;
    end else begin
      if (frame_err) begin
        Frame_Error <= 1'b1;
      end
      case (ld_state)
        WAIT_LEN: begin
          if (byte_valid) begin
            length     <= (rx_shift == 8'h00) ? 9'd256 : {1'b0, rx_shift};
            written    <= 9'd0;
            write_addr <= 8'h00;
            Load_Count <= 8'h00;
            ld_state   <= LOAD;
          end
        end
        LOAD: begin
          if (frame_err) begin
            ld_state   <= WAIT_LEN;
            written    <= 9'd0;
            write_addr <= 8'h00;
            Load_Count <= 8'h00;
          end else if (byte_valid) begin
            written    <= written + 9'd1;
            write_addr <= write_addr + 8'd1;
            Load_Count <= Load_Count + 8'd1;
            if (written + 9'd1 == length) begin
              ld_state  <= RUN;
              CPU_Reset <= 1'b0;
              Loading   <= 1'b0;
            end
          end
        end
        RUN: begin
          CPU_Reset <= 1'b0;
          Loading   <= 1'b0;
        end
        default: ld_state <= WAIT_LEN;
      endcase
    end
  end

  // Program memory write port; contents survive reset and reload.
  always_ff @(posedge Clk_O) begin
    if (mem_we) begin
      mem[write_addr] <= rx_shift;
    end
  end

  // Combinational instruction fetch, gated to the loaded program while running.
  always_comb begin
    Instruction = 8'h00;
    if ((ld_state == RUN) && ({1'b0, PC} < length)) begin
      Instruction = mem[PC];
    end
  end

endmodule
